// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: shifts S_IN into WORD_W-bit frames delimited by SYNC and queues good words in a FWFT FIFO.
// Optional parity checking (extra even-parity bit per frame) is compiled in with `define SERIAL_FRAME_PARITY_EN.
module serial_frame_receiver #(
    parameter int WORD_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 1
) (
    input  logic                                LINK_CLK,
    input  logic                                RESET,
    input  logic                                S_IN,
    input  logic                                SYNC,
    output logic [WORD_W-1:0]                   OUT_DATA,
    output logic                                OUT_VALID,
    input  logic                                OUT_READY,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     FIFO_LEVEL,
    output logic                                FRAME_ERR,
    output logic                                PAR_ERR,
    output logic                                OVERFLOW,
    input  logic                                CLR_OVF
);

`ifdef SERIAL_FRAME_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    localparam int F     = WORD_W + PAR_BITS;
    localparam int CNT_W = $clog2(F + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(F);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(F - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [WORD_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              frame_err_q, frame_err_d;
    logic              par_err_q, par_err_d;
    logic              ovf_q, ovf_d;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0] mem_d [FIFO_DEPTH];

    logic [WORD_W-1:0] shift_nx;
    logic [WORD_W-1:0] word;
    logic              par_bad;
    logic              len_ok;
    logic              good;
    logic              pop;
    logic              full;
    logic              ovf_set;
    logic              wr_en;

    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        shift_nx = shift_q;
        word     = '0;
        par_bad  = 1'b0;

        if (MSB_FIRST != 0) begin
            shift_nx = {shift_q[WORD_W-2:0], S_IN};
        end else begin
            shift_nx = {S_IN, shift_q[WORD_W-1:1]};
        end

`ifdef SERIAL_FRAME_PARITY_EN
        // The SYNC bit is the parity bit, so the payload is what was already shifted in.
        word    = shift_q;
        par_bad = (^shift_q) ^ S_IN;
`else
        word    = shift_nx;
        par_bad = 1'b0;
`endif

        shift_d = shift_nx;
        len_ok  = (cnt_q == CNT_LAST);
        good    = SYNC && len_ok && !par_bad;

        if (SYNC) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_SAT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        frame_err_d = SYNC && !len_ok;
        par_err_d   = SYNC && len_ok && par_bad;

        pop     = (level_q != '0) && OUT_READY;
        full    = (level_q == LVL_FULL);
        ovf_set = good && full && !pop;
        wr_en   = good && !ovf_set;

        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = word;
        end

        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        case ({wr_en, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge LINK_CLK) begin
        if (RESET) begin
            shift_q     <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
            ovf_q       <= ovf_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; OUT_DATA is gated by OUT_VALID so stale entries never show.
    always_ff @(posedge LINK_CLK) begin
        mem_q <= mem_d;
    end

    assign OUT_VALID  = (level_q != '0);
    assign OUT_DATA   = OUT_VALID ? mem_q[rd_ptr_q] : '0;
    assign FIFO_LEVEL = level_q;
    assign FRAME_ERR  = frame_err_q;
    assign PAR_ERR    = par_err_q;
    assign OVERFLOW   = ovf_q;

endmodule

// File: doc/serial_frame_receiver.md
SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

Interface
REQ-001 Parameter WORD_W, default 16, payload bits per frame, range 2..64.
REQ-002 Parameter FIFO_DEPTH, default 4, output FIFO entries, power of two, range 2..32.
REQ-003 Parameter MSB_FIRST, default 1; 1 = first received bit lands in OUT_DATA[WORD_W-1], 0 = first received bit lands in OUT_DATA[0].
REQ-004 LINK_CLK  input  1  sole clock, all logic on rising edge.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 S_IN  input  1  serial data, one bit sampled every LINK_CLK cycle.
REQ-007 SYNC  input  1  high in the cycle carrying the last bit of a frame.
REQ-008 OUT_DATA  output  WORD_W  FIFO head word, valid only while OUT_VALID=1.
REQ-009 OUT_VALID  output  1  FIFO non-empty.
REQ-010 OUT_READY  input  1  consumer accept; a pop occurs when OUT_VALID & OUT_READY are both high.
REQ-011 FIFO_LEVEL  output  clog2(FIFO_DEPTH+1)  current number of stored words.
REQ-012 FRAME_ERR  output  1  one-cycle pulse when a frame has the wrong length.
REQ-013 PAR_ERR  output  1  one-cycle pulse when a frame fails parity (constant 0 without PARITY_EN).
REQ-014 OVERFLOW  output  1  sticky flag, set when a good word is dropped because the FIFO is full.
REQ-015 CLR_OVF  input  1  clears OVERFLOW.

Function
REQ-016 Frame length F SHALL be WORD_W, or WORD_W+1 with PARITY_EN; S_IN SHALL be shifted into a frame register every cycle, regardless of SYNC.
REQ-017 Bit counter CNT SHALL count bits received since the last SYNC cycle, increment by 1 per non-SYNC cycle, and saturate at F.
REQ-018 In a SYNC cycle, the frame SHALL be good iff CNT==F-1 (parity rules are in REQ-031/032); CNT SHALL return to 0 in every SYNC cycle.
REQ-019 A length mismatch in a SYNC cycle SHALL assert FRAME_ERR for exactly the next cycle; the word SHALL be discarded.
REQ-020 A good word SHALL be written to the FIFO at the end of its SYNC cycle and SHALL appear on OUT_DATA/OUT_VALID in the following cycle if the FIFO was empty (1-cycle latency, first-word fall-through).
REQ-021 The FIFO SHALL be strict FIFO order; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 On a simultaneous push and pop, FIFO_LEVEL SHALL be unchanged; when full, a simultaneous push and pop SHALL accept the new word.
REQ-023 A push while full without a pop SHALL drop the new word, keep the FIFO contents, and set OVERFLOW.
REQ-024 CLR_OVF SHALL clear OVERFLOW the next cycle; if a set event occurs in the same cycle as CLR_OVF, the set event SHALL win.
REQ-025 A pop while empty SHALL have no effect.
REQ-026 FRAME_ERR and PAR_ERR SHALL never both assert for the same frame; a length error SHALL take priority.

Reset
REQ-027 While RESET=1: CNT=0, frame register=0, FIFO empty (pointers 0), OUT_VALID=0, FIFO_LEVEL=0, FRAME_ERR=0, PAR_ERR=0, OVERFLOW=0, and OUT_DATA=0.
REQ-028 A frame in progress when RESET asserts SHALL be abandoned; after release, the first good frame requires F-1 bits followed by a SYNC bit.
REQ-029 SYNC and S_IN SHALL be ignored in any cycle in which RESET=1.

Configuration
REQ-030 Macro SERIAL_FRAME_PARITY_EN SHALL compile in parity checking; without it, F=WORD_W and PAR_ERR SHALL be tied to 0.
REQ-031 With the macro, the last bit of each frame (the SYNC bit) SHALL be an even-parity bit over the WORD_W payload bits, and SHALL NOT be stored.
REQ-032 With the macro, a correct-length frame whose XOR over all F bits is 1 SHALL pulse PAR_ERR for the next cycle and SHALL NOT be pushed.

Verification
REQ-033 WORD_W=16, MSB_FIRST=1, no macro: shift 0xA5C3 MSB first, SYNC on the 16th bit -> OUT_VALID=1 and OUT_DATA=0xA5C3 one cycle later; FIFO_LEVEL=1.
REQ-034 SYNC on the 15th bit -> FRAME_ERR pulses once, FIFO_LEVEL stays 0; a following 16-bit frame 0x0001 is accepted.
REQ-035 OUT_READY=0; push 5 frames (0x0001..0x0005) with FIFO_DEPTH=4 -> FIFO_LEVEL=4 and OVERFLOW=1; drain -> 0x0001..0x0004 in order; CLR_OVF -> OVERFLOW=0.
REQ-036 FIFO full with OUT_READY=1 in the push cycle -> no overflow, FIFO_LEVEL stays 4, and the last word read is the new word.
REQ-037 With the macro: send payload 0x0003 with parity bit 0 -> accepted; send payload 0x0007 with parity bit 0 -> PAR_ERR pulse, not stored.
REQ-038 Assert RESET after 8 bits of a frame, then send a full 16-bit frame 0x1234 -> only 0x1234 is output, with no FRAME_ERR.
